sram_dp_clear: RTL and testbench

SRAM_DP_CLEAR -- requirements
Module: sram_dp_clear

---
 rtl/sram_dp_pkg.sv | 15 +
 rtl/sram_dp_bank.sv | 37 +++
 rtl/sram_dp_clear.sv | 214 +++++++++++++++++++++
 tb/tb_sram_dp_clear.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_dp_pkg.sv
// Shared types and constants for the dual-port SRAM with a clear engine.
package sram_dp_pkg;

  // Clear engine states: ST_CLEAR is also the reset state, so every reset
  // release zeroes the whole array.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Same-address read-during-write behaviour across the two ports.
  localparam int RDW_OLD = 0;  // reader sees the word as it was before the write
  localparam int RDW_NEW = 1;  // reader sees the byte-merged word being written

endpackage

// File: rtl/sram_dp_bank.sv
// Plain two-port byte-enabled storage array with no reset.
// Reads are combinational; the owning block registers the read data.
// When both ports write the same word, port A wins on overlapping bytes.
module sram_dp_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   wdata_a,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  output logic [DATA_WIDTH-1:0]   rdata_b
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-masked writes; port A is assigned last so it takes overlapping bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
      if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
    end
  end

  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];

endmodule

// File: rtl/sram_dp_clear.sv
// Dual-port byte-enabled SRAM with a whole-array clear engine.
//
// Handshake: a port access is a one-cycle strobe (enableX). A read is
// answered by a one-cycle validX pulse one cycle later (two with OUT_REG=1),
// with dataOutX holding the word until the next read completes. Writes never
// pulse valid. While busy is high every port strobe is dropped and no
// handshake occurs; there is no backpressure.
module sram_dp_clear
  import sram_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    clearRequest,
  output logic                    busy,
  input  logic                    enableA,
  input  logic                    writeEnableA,
  input  logic [DATA_WIDTH/8-1:0] byteEnableA,
  input  logic [ADDR_WIDTH-1:0]   addressA,
  input  logic [DATA_WIDTH-1:0]   dataInA,
  output logic [DATA_WIDTH-1:0]   dataOutA,
  output logic                    validA,
  input  logic                    enableB,
  input  logic                    writeEnableB,
  input  logic [DATA_WIDTH/8-1:0] byteEnableB,
  input  logic [ADDR_WIDTH-1:0]   addressB,
  input  logic [DATA_WIDTH-1:0]   dataInB,
  output logic [DATA_WIDTH-1:0]   dataOutB,
  output logic                    validB,
  output logic                    collision,
  output logic                    debugState
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Clear engine state
  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // First output stage
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic                  rd_valid_a_q, rd_valid_a_d;
  logic                  rd_valid_b_q, rd_valid_b_d;
  logic                  collision_q, collision_d;

  // Qualified port operations (dropped while the clear runs)
  logic rd_a, wr_a, rd_b, wr_b;

  // Bank connections
  logic                  bank_we_a;
  logic [NUM_BYTES-1:0]  bank_be_a;
  logic [ADDR_WIDTH-1:0] bank_addr_a;
  logic [DATA_WIDTH-1:0] bank_wdata_a;
  logic [DATA_WIDTH-1:0] bank_rdata_a, bank_rdata_b;

  // Read words after optional write-through merge
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

  assign busy       = (state_q == ST_CLEAR);
  assign debugState = state_q;

  assign rd_a = enableA & ~writeEnableA & ~busy;
  assign wr_a = enableA &  writeEnableA & ~busy;
  assign rd_b = enableB & ~writeEnableB & ~busy;
  assign wr_b = enableB &  writeEnableB & ~busy;

  // Port A of the bank is borrowed by the clear engine while busy.
  always_comb begin
    bank_we_a    = wr_a;
    bank_be_a    = byteEnableA;
    bank_addr_a  = addressA;
    bank_wdata_a = dataInA;
    if (busy) begin
      bank_we_a    = 1'b1;
      bank_be_a    = '1;
      bank_addr_a  = cnt_q;
      bank_wdata_a = '0;
    end
  end

  sram_dp_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk     (clock),
    .we_a    (bank_we_a),
    .be_a    (bank_be_a),
    .addr_a  (bank_addr_a),
    .wdata_a (bank_wdata_a),
    .rdata_a (bank_rdata_a),
    .we_b    (wr_b),
    .be_b    (byteEnableB),
    .addr_b  (addressB),
    .wdata_b (dataInB),
    .rdata_b (bank_rdata_b)
  );

  // Write-through: overlay the other port's enabled bytes on a same-address read.
  always_comb begin
    rd_word_a = bank_rdata_a;
    rd_word_b = bank_rdata_b;
    if (RDW_MODE == RDW_NEW) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_b && (addressB == addressA) && byteEnableB[i])
          rd_word_a[8*i +: 8] = dataInB[8*i +: 8];
        if (wr_a && (addressA == addressB) && byteEnableA[i])
          rd_word_b[8*i +: 8] = dataInA[8*i +: 8];
      end
    end
  end

  // Next-state for the clear engine: count up once, stop at the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clearRequest) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-value for the first output stage and the collision pulse.
  always_comb begin
    rd_data_a_d  = rd_a ? rd_word_a : rd_data_a_q;
    rd_data_b_d  = rd_b ? rd_word_b : rd_data_b_q;
    rd_valid_a_d = rd_a;
    rd_valid_b_d = rd_b;
    collision_d  = wr_a & wr_b & (addressA == addressB);
  end

  // Registers for the clear engine and first output stage.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      collision_q  <= collision_d;
    end
  end

  assign collision = collision_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
      logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
      logic                  out_valid_a_q, out_valid_a_d;
      logic                  out_valid_b_q, out_valid_b_d;

      // Second stage only loads when the first stage carries a new word.
      always_comb begin
        out_a_d       = rd_valid_a_q ? rd_data_a_q : out_a_q;
        out_b_d       = rd_valid_b_q ? rd_data_b_q : out_b_q;
        out_valid_a_d = rd_valid_a_q;
        out_valid_b_d = rd_valid_b_q;
      end

      // Output pipeline registers.
      always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
          out_a_q       <= '0;
          out_b_q       <= '0;
          out_valid_a_q <= 1'b0;
          out_valid_b_q <= 1'b0;
        end else begin
          out_a_q       <= out_a_d;
          out_b_q       <= out_b_d;
          out_valid_a_q <= out_valid_a_d;
          out_valid_b_q <= out_valid_b_d;
        end
      end

      assign dataOutA = out_a_q;
      assign dataOutB = out_b_q;
      assign validA   = out_valid_a_q;
      assign validB   = out_valid_b_q;
    end else begin : g_no_out_reg
      assign dataOutA = rd_data_a_q;
      assign dataOutB = rd_data_b_q;
      assign validA   = rd_valid_a_q;
      assign validB   = rd_valid_b_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_clear.sv
// Directed bench for sram_dp_clear. Two instances share all inputs:
// dut0 = read-old-data, no output register; dut1 = write-through, output register.
module tb_sram_dp_clear;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clock;
  logic          resetN;
  logic          clearRequest;
  logic          enableA, writeEnableA, enableB, writeEnableB;
  logic [3:0]    byteEnableA, byteEnableB;
  logic [AW-1:0] addressA, addressB;
  logic [DW-1:0] dataInA, dataInB;

  logic          busy0, busy1, dbg0, dbg1;
  logic [DW-1:0] out_a0, out_b0, out_a1, out_b1;
  logic          va0, vb0, va1, vb1, col0, col1;

  int total;
  int bad;

  sram_dp_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clock(clock), .resetN(resetN), .clearRequest(clearRequest), .busy(busy0),
    .enableA(enableA), .writeEnableA(writeEnableA), .byteEnableA(byteEnableA),
    .addressA(addressA), .dataInA(dataInA), .dataOutA(out_a0), .validA(va0),
    .enableB(enableB), .writeEnableB(writeEnableB), .byteEnableB(byteEnableB),
    .addressB(addressB), .dataInB(dataInB), .dataOutB(out_b0), .validB(vb0),
    .collision(col0), .debugState(dbg0)
  );

  sram_dp_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clock(clock), .resetN(resetN), .clearRequest(clearRequest), .busy(busy1),
    .enableA(enableA), .writeEnableA(writeEnableA), .byteEnableA(byteEnableA),
    .addressA(addressA), .dataInA(dataInA), .dataOutA(out_a1), .validA(va1),
    .enableB(enableB), .writeEnableB(writeEnableB), .byteEnableB(byteEnableB),
    .addressB(addressB), .dataInB(dataInB), .dataOutB(out_b1), .validB(vb1),
    .collision(col1), .debugState(dbg1)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks (all called at a negedge, all return at a negedge)
  task automatic idle_ports();
    enableA = 1'b0; writeEnableA = 1'b0; byteEnableA = '0; addressA = '0; dataInA = '0;
    enableB = 1'b0; writeEnableB = 1'b0; byteEnableB = '0; addressB = '0; dataInB = '0;
  endtask

  task automatic drive_a(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    enableA = 1'b1; writeEnableA = we; byteEnableA = be; addressA = addr; dataInA = data;
  endtask

  task automatic drive_b(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    enableB = 1'b1; writeEnableB = we; byteEnableB = be; addressB = addr; dataInB = data;
  endtask

  task automatic do_write(input bit on_b, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] be);
    if (on_b) drive_b(1'b1, be, addr, data);
    else      drive_a(1'b1, be, addr, data);
    @(negedge clock);
    idle_ports();
    check("wr_no_valid", {28'd0, va0, vb0, va1, vb1}, '0);
  endtask

  task automatic do_read(input bit on_b, input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                         input string tag);
    if (on_b) drive_b(1'b0, 4'h0, addr, '0);
    else      drive_a(1'b0, 4'h0, addr, '0);
    @(negedge clock);
    idle_ports();
    check({tag, "_v0"}, on_b ? vb0 : va0, 1);
    check({tag, "_d0"}, on_b ? out_b0 : out_a0, exp);
    check({tag, "_v1_early"}, on_b ? vb1 : va1, 0);
    @(negedge clock);
    check({tag, "_v1"}, on_b ? vb1 : va1, 1);
    check({tag, "_d1"}, on_b ? out_b1 : out_a1, exp);
    check({tag, "_v0_once"}, on_b ? vb0 : va0, 0);
  endtask

  // Counts busy cycles starting at the current negedge, bounded.
  task automatic count_busy(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      @(negedge clock);
    end
  endtask

  // Scoreboard-style expected queue of words expected back from addr 0..15 after reset clear
  logic [DW-1:0] exp_q[$];

  initial begin
    int n0, n1;
    total = 0;
    bad   = 0;
    clearRequest = 1'b0;
    idle_ports();
    resetN = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", {30'd0, busy0, busy1}, 32'h3);
    check("rst_state", {30'd0, dbg0, dbg1}, 32'h3);
    check("rst_out", out_a0 | out_b0 | out_a1 | out_b1, '0);
    check("rst_pulses", {26'd0, va0, vb0, va1, vb1, col0, col1}, '0);

    // Reset release: busy for exactly 16 cycles
    resetN = 1'b1;
    count_busy(n0, n1);
    check("rel_busy0", n0, 16);
    check("rel_busy1", n1, 16);
    check("rel_idle", {30'd0, dbg0, dbg1}, '0);

    // Every word cleared
    for (int a = 0; a < 16; a++) exp_q.push_back('0);
    for (int a = 0; a < 16; a++) do_read(1'b0, AW'(a), exp_q.pop_front(), "clr_rd_a");
    do_read(1'b1, 4'd15, 32'h0, "clr_rd_b");

    // Byte-masked write onto zero
    do_write(1'b0, 4'd3, 32'hAABBCCDD, 4'b0101);
    do_read(1'b0, 4'd3, 32'h00BB00DD, "be_rd");
    // Writes leave dataOut alone
    do_write(1'b0, 4'd8, 32'h0BADF00D, 4'hF);
    check("hold_a0", out_a0, 32'h00BB00DD);
    check("hold_a1", out_a1, 32'h00BB00DD);
    // byteEnable all-zero leaves memory unchanged
    do_write(1'b0, 4'd3, 32'hFFFFFFFF, 4'h0);
    do_read(1'b1, 4'd3, 32'h00BB00DD, "be0_rd");

    // A writes, B reads same address
    do_write(1'b0, 4'd5, 32'h11111111, 4'hF);
    drive_a(1'b1, 4'hF, 4'd5, 32'h22222222);
    drive_b(1'b0, 4'h0, 4'd5, '0);
    @(negedge clock);
    idle_ports();
    check("rdw_b_v0", vb0, 1);
    check("rdw_b_old", out_b0, 32'h11111111);
    check("rdw_a_nov", va0, 0);
    @(negedge clock);
    check("rdw_b_v1", vb1, 1);
    check("rdw_b_new", out_b1, 32'h22222222);
    do_read(1'b0, 4'd5, 32'h22222222, "rdw_after");

    // B writes (partial bytes), A reads same address
    do_write(1'b1, 4'd6, 32'h55555555, 4'hF);
    drive_b(1'b1, 4'b0011, 4'd6, 32'h0000ABCD);
    drive_a(1'b0, 4'h0, 4'd6, '0);
    @(negedge clock);
    idle_ports();
    check("rdw_a_v0", va0, 1);
    check("rdw_a_old", out_a0, 32'h55555555);
    @(negedge clock);
    check("rdw_a_v1", va1, 1);
    check("rdw_a_merge", out_a1, 32'h5555ABCD);
    do_read(1'b1, 4'd6, 32'h5555ABCD, "rdw_swap_after");

    // Both write addr 7: A wins overlapping bytes
    drive_a(1'b1, 4'b1100, 4'd7, 32'hFFFF0000);
    drive_b(1'b1, 4'b0110, 4'd7, 32'h12345678);
    @(negedge clock);
    idle_ports();
    check("coll_pulse", {30'd0, col0, col1}, 32'h3);
    @(negedge clock);
    check("coll_once", {30'd0, col0, col1}, 32'h0);
    do_read(1'b0, 4'd7, 32'hFFFF5600, "coll_word");
    // Different addresses: no collision
    drive_a(1'b1, 4'hF, 4'd10, 32'h1);
    drive_b(1'b1, 4'hF, 4'd11, 32'h2);
    @(negedge clock);
    idle_ports();
    check("no_coll", {30'd0, col0, col1}, 32'h0);

    // Clear request with a read in the same cycle; port activity during busy ignored
    clearRequest = 1'b1;
    drive_a(1'b0, 4'h0, 4'd3, '0);
    @(negedge clock);
    clearRequest = 1'b0;
    idle_ports();
    n0 = 0;
    n1 = 0;
    for (int i = 1; i <= 24; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (i == 1) begin
        check("req_rd_v0", va0, 1);
        check("req_rd_d0", out_a0, 32'h00BB00DD);
      end else if (i == 2) begin
        check("req_rd_v1", va1, 1);
        check("req_rd_d1", out_a1, 32'h00BB00DD);
        check("req_rd_v0_once", va0, 0);
      end else if (i <= 17) begin
        check("busy_quiet", {26'd0, va0, vb0, va1, vb1, col0, col1}, '0);
      end
      clearRequest = (i == 3);
      idle_ports();
      if (i == 5) begin
        drive_a(1'b1, 4'hF, 4'd7, 32'hDEADBEEF);
        drive_b(1'b1, 4'hF, 4'd7, 32'hFEEDFACE);
      end else if (i == 10) begin
        drive_a(1'b1, 4'hF, 4'd1, 32'h77777777);
        drive_b(1'b0, 4'h0, 4'd2, '0);
      end else if (i == 12) begin
        drive_a(1'b0, 4'h0, 4'd0, '0);
      end
      @(negedge clock);
    end
    idle_ports();
    check("clr_busy0", n0, 16);
    check("clr_busy1", n1, 16);
    check("clr_done", {30'd0, dbg0, dbg1}, '0);
    do_read(1'b0, 4'd1, 32'h0, "busy_wr_dropped");
    do_read(1'b1, 4'd7, 32'h0, "clr_7");
    do_read(1'b0, 4'd3, 32'h0, "clr_3");

    // Reset in the middle of a clear restarts it from address 0
    do_write(1'b0, 4'd4, 32'hCAFEF00D, 4'hF);
    do_read(1'b0, 4'd4, 32'hCAFEF00D, "pre_rst");
    clearRequest = 1'b1;
    @(negedge clock);
    clearRequest = 1'b0;
    repeat (6) @(negedge clock);
    resetN = 1'b0;
    #2;
    check("mid_rst_out", out_a0 | out_a1, '0);
    check("mid_rst_busy", {30'd0, busy0, busy1}, 32'h3);
    @(negedge clock);
    resetN = 1'b1;
    count_busy(n0, n1);
    check("restart_busy0", n0, 16);
    check("restart_busy1", n1, 16);
    do_read(1'b0, 4'd4, 32'h0, "restart_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
